// File: rtl/audio_pkg.sv
// Shared types, defaults and helpers for the cabinet audio output path.
package audio_pkg;

  typedef enum logic [1:0] {
    VOL_0DB  = 2'd0,
    VOL_6DB  = 2'd1,
    VOL_12DB = 2'd2,
    VOL_OFF  = 2'd3
  } vol_t;

  localparam int unsigned LPF_SHIFT_DEF = 4;
  localparam int unsigned DCB_SHIFT_DEF = 8;

  function automatic logic signed [15:0] sat18to16(input logic signed [17:0] x);
    if (x > 18'sd32767) begin
      return 16'sh7FFF;
    end else if (x < -18'sd32768) begin
      return 16'sh8000;
    end else begin
      return x[15:0];
    end
  endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: 1-bit DAC stream from a held signed PCM sample.
module sigma_delta_dac (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] sample,
  output logic               dac_bit
);

  logic [15:0] u;
  logic [15:0] sd_acc_q, sd_acc_d;
  logic        dac_bit_q, dac_bit_d;

  always_comb begin
    // Offset-binary view of the sample: -32768 maps to 0, 32767 to 0xFFFF.
    u = {~sample[15], sample[14:0]};
    {dac_bit_d, sd_acc_d} = {1'b0, sd_acc_q} + {1'b0, u};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sd_acc_q  <= '0;
      dac_bit_q <= 1'b0;
    end else begin
      sd_acc_q  <= sd_acc_d;
      dac_bit_q <= dac_bit_d;
    end
  end

  assign dac_bit = dac_bit_q;

endmodule

// File: rtl/audio_output_stage.sv
// Mixer output -> IIR low-pass -> 48 kHz decimation -> DC blocker -> volume/mute -> PCM + 1-bit DAC.
module audio_output_stage
  import audio_pkg::*;
#(
  parameter int unsigned LPF_SHIFT = LPF_SHIFT_DEF,
  parameter int unsigned DCB_SHIFT = DCB_SHIFT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_3MHz_en,
  input  logic               clk_48KHz_en,
  input  logic [15:0]        in,
  input  logic [1:0]         vol,
  input  logic               mute,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  output logic               dac_bit
);

  localparam int unsigned AccW = 16 + LPF_SHIFT;

  logic [AccW-1:0]    lpf_acc_q, lpf_acc_d;
  logic [15:0]        lpf_out;
  logic [15:0]        l_prev_q, l_prev_d;
  logic signed [15:0] y_prev_q, y_prev_d;
  logic signed [15:0] y;
  logic signed [15:0] sample_q, sample_d;
  logic               sample_valid_q, sample_valid_d;
  logic signed [17:0] l_ext, l_prev_ext, y_prev_ext, dcb_sum;
  vol_t               vol_sel;

  assign lpf_out = lpf_acc_q[AccW-1:LPF_SHIFT];

  always_comb begin
    lpf_acc_d = lpf_acc_q;
    if (clk_3MHz_en) begin
      lpf_acc_d = lpf_acc_q - {{LPF_SHIFT{1'b0}}, lpf_out} + {{LPF_SHIFT{1'b0}}, in};
    end
  end

  // Uses the pre-update LPF value, so a coincident 3 MHz enable is not seen until the next tick.
  always_comb begin
    l_ext      = $signed({2'b00, lpf_out});
    l_prev_ext = $signed({2'b00, l_prev_q});
    y_prev_ext = $signed({{2{y_prev_q[15]}}, y_prev_q});
    dcb_sum    = l_ext - l_prev_ext + y_prev_ext - (y_prev_ext >>> DCB_SHIFT);
    y          = sat18to16(dcb_sum);
  end

  always_comb begin
    vol_sel        = vol_t'(vol);
    l_prev_d       = l_prev_q;
    y_prev_d       = y_prev_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    if (clk_48KHz_en) begin
      l_prev_d       = lpf_out;
      y_prev_d       = y;
      sample_valid_d = 1'b1;
      if (mute) begin
        sample_d = '0;
      end else begin
        unique case (vol_sel)
          VOL_0DB:  sample_d = y;
          VOL_6DB:  sample_d = y >>> 1;
          VOL_12DB: sample_d = y >>> 2;
          VOL_OFF:  sample_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lpf_acc_q      <= '0;
      l_prev_q       <= '0;
      y_prev_q       <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      lpf_acc_q      <= lpf_acc_d;
      l_prev_q       <= l_prev_d;
      y_prev_q       <= y_prev_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  sigma_delta_dac u_sigma_delta_dac (
    .clk     (clk),
    .rst     (rst),
    .sample  (sample_q),
    .dac_bit (dac_bit)
  );

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: doc/audio_output_stage.md
# audio_output_stage

Final stage of the cabinet audio path, directly downstream of the analog sound mixer. It takes the mixer's 16-bit unsigned output, updated on the 3 MHz enable, and applies a first-order IIR low-pass at 3 MHz. It decimates the result to 48 kHz, removes DC with a one-pole high-pass, and applies volume/mute to produce a signed 16-bit PCM sample with a valid strobe. A first-order sigma-delta modulator also drives a 1-bit DAC pin from the held sample.

## Interface
Parameters:
- LPF_SHIFT, 4: low-pass coefficient 2^-LPF_SHIFT (range 1–8).
- DCB_SHIFT, 8: DC-blocker pole coefficient 2^-DCB_SHIFT (range 4–12).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- clk_3MHz_en  in  1  one-cycle enable; mixer output valid, LPF update.
- clk_48KHz_en  in  1  one-cycle enable; decimation/output tick.
- in  in  16  mixer output, unsigned.
- vol  in  2  attenuation: 0 = 0 dB, 1 = −6 dB, 2 = −12 dB, 3 = off.
- mute  in  1  forces output sample to 0.
- sample  out  16  signed PCM, held between valid pulses.
- sample_valid  out  1  one-cycle pulse per new sample.
- dac_bit  out  1  sigma-delta bitstream, updated every clk.

## Operation
- **LPF:**
  - State lpf_acc is unsigned, 16+LPF_SHIFT bits.
  - On clk_3MHz_en: lpf_acc <= lpf_acc + in − lpf_acc[top:LPF_SHIFT].
  - LPF output is lpf_acc >> LPF_SHIFT; it never exceeds 0xFFFF.
- **Decimation/DC block**, on clk_48KHz_en:
  - l = LPF output, zero-extended to 18-bit signed.
  - d = l − l_prev + y_prev − (y_prev >>> DCB_SHIFT), computed at 18 bits.
  - d saturates to [−32768, 32767] to form y.
  - Then l_prev <= l and y_prev <= y.
- **Volume:**
  - sample <= (mute or vol==3) ? 0 : y >>> vol (arithmetic shift).
  - The DC-blocker state updates regardless of mute/vol.
- **Sigma-delta:**
  - Every clk, u = {~sample[15], sample[14:0]}.
  - {dac_bit, sd_acc} <= sd_acc + u, computed at 17 bits.
  - dac_bit is the carry.
- No state machine beyond the enable-driven pipeline. Enables may be arbitrary; there is no assumption of a 62.5:1 ratio.

## Timing
- **Reset values:** lpf_acc, l_prev, y_prev, sd_acc, sample, sample_valid and dac_bit are all 0. Reset overrides any enable in the same cycle.
- **LPF latency:** new lpf_acc is visible the cycle after clk_3MHz_en.
- **Simultaneous enables:** when clk_3MHz_en and clk_48KHz_en coincide, the decimator uses the pre-update LPF value.
- **sample/sample_valid:** sample and sample_valid change the cycle after clk_48KHz_en. sample_valid stays high for exactly one cycle.
- **Back-to-back ticks:** clk_48KHz_en on consecutive cycles gives consecutive valid pulses, each with its own update.
- **vol/mute** are sampled only on clk_48KHz_en; changes between ticks have no effect until the next tick.
- **dac_bit** reflects sample one cycle after sample changes.
- **Reset mid-operation:** all state returns to reset values. The first post-reset tick treats l_prev = 0, so the first sample equals the current LPF output, saturated.

## Structure
- **Package audio_pkg:**
  - Typedef vol_t (enum: VOL_0DB, VOL_6DB, VOL_12DB, VOL_OFF).
  - Constants LPF_SHIFT_DEF = 4, DCB_SHIFT_DEF = 8.
  - Saturating function sat18to16.
- **Sub-module sigma_delta_dac:** inputs clk, rst, 16-bit signed sample; output dac_bit. Instantiated once.
- **Top (audio_output_stage):** LPF, DC blocker, volume stage and strobe.

## Test plan
1. **LPF step.** Reset, then in = 0x4000 and a single clk_3MHz_en. Require LPF output = 0x0400. After ≥200 enables, LPF output = 0x4000 ±1.
2. **DC-block step.** LPF settled at 0x4000, previously 0, with vol = 0. First clk_48KHz_en gives sample = 0x4000 and sample_valid high for 1 cycle. With no further input change, over 2000 ticks |sample| decays below 0x0100 monotonically.
3. **Saturation.** Force the LPF output from 0xFFFF to 0x0000 between ticks after DC settle. Require sample = 0x8000 (−32768), not wrapped.
4. **Volume/mute.** y = 0x2000 steady per tick. vol = 1 gives 0x1000; vol = 2 gives 0x0800; vol = 3 or mute = 1 gives 0. Releasing mute restores 0x2000 at the next tick, showing the DC state continued.
5. **Sigma-delta.**
   - sample = 0 gives dac_bit alternating 0,1 from reset.
   - sample = 0x7FFF gives 65535 ones per 65536 cycles.
   - sample = 0x8000 gives all zeros.
6. **Coincident enables and reset.**
   - clk_3MHz_en and clk_48KHz_en in the same cycle: sample uses the old LPF value.
   - rst asserted in the same cycle as clk_48KHz_en: no sample_valid, all outputs 0 next cycle.
